data_mem_stage: RTL and testbench

Memory-access stage of the core pipeline: the responder for the `tMemOp` request the ALU stage issues inside `tAluOut`. It owns the data RAM and performs byte/half/word loads and stores. It returns a `tRegOp` writeback to the register file, merging load results with the ALU's own `regOp` results in program order.

---
 rtl/data_mem_stage_pkg.sv | 79 +++++++
 rtl/data_mem_stage_if.sv | 31 +++
 rtl/data_mem_stage_ram.sv | 29 ++
 rtl/data_mem_stage.sv | 143 ++++++++++++++
 tb/tb_data_mem_stage.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/data_mem_stage_pkg.sv
// Shared types for the memory-access stage: ALU-to-memory request, register
// writeback, S1 pipeline state and the load lane/extension helpers.
package data_mem_stage_pkg;

    localparam int cXLEN     = 32;
    localparam int cRamDepth = 1024;
    localparam int cRamAddrW = $clog2(cRamDepth);

    // funct3 codes; the store codes SB/SH/SW reuse eLb/eLh/eLw
    typedef enum logic [2:0] {
        eLb  = 3'b000,
        eLh  = 3'b001,
        eLw  = 3'b010,
        eLbu = 3'b100,
        eLhu = 3'b101
    } tMemOpType;

    typedef struct packed {
        logic             dv;
        logic [4:0]       addr;
        logic [cXLEN-1:0] data;
    } tRegOp;

    typedef struct packed {
        logic             read;
        logic             write;
        tMemOpType        opType;
        logic [cXLEN-1:0] addr;
        logic [cXLEN-1:0] data;
        logic [4:0]       rdAddr;
    } tMemOp;

    typedef struct packed {
        logic             dv;
        logic [cXLEN-1:0] target;
    } tBrchOp;

    typedef struct packed {
        tMemOp  memOp;
        tRegOp  regOp;
        tBrchOp brchOp;
    } tAluOut;

    // S1 state: dv already accounts for x0, illegal and misaligned accesses
    typedef struct packed {
        logic      dv;
        logic      isLoad;
        tMemOpType opType;
        logic [1:0] lane;
        logic [4:0] rdAddr;
        tRegOp     regOp;
    } tMemStage;

    // Right-align the addressed lane of a RAM word and extend it to cXLEN
    function automatic logic [cXLEN-1:0] loadExtend(tMemOpType opType, logic [1:0] lane,
                                                    logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (opType)
            eLb:     return {{24{b[7]}}, b};
            eLh:     return {{16{h[15]}}, h};
            eLbu:    return {24'd0, b};
            eLhu:    return {16'd0, h};
            default: return word;
        endcase
    endfunction

    // Halves need addr[0]=0, words need addr[1:0]=0
    function automatic logic misaligned(tMemOpType opType, logic [1:0] lane);
        case (opType)
            eLh, eLhu: return lane[0];
            eLw:       return lane != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_stage_if.sv
// Bus between the ALU stage (master) and the memory stage (slave).
// oMisalign exists only when DATA_MEM_ALIGN_CHECK_EN is defined.
interface data_mem_stage_if;
    import data_mem_stage_pkg::*;

    tAluOut iAluOut;
    tRegOp  oRegOp;
    tRegOp  oLoadPend;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic   oMisalign;
`endif

    modport master (
        output iAluOut,
        input  oRegOp,
        input  oLoadPend
`ifdef DATA_MEM_ALIGN_CHECK_EN
        , input oMisalign
`endif
    );

    modport slave (
        input  iAluOut,
        output oRegOp,
        output oLoadPend
`ifdef DATA_MEM_ALIGN_CHECK_EN
        , output oMisalign
`endif
    );

endinterface

// File: rtl/data_mem_stage_ram.sv
// Single-port data RAM, pDepth x 32, byte write enables, registered read,
// contents not reset.
module data_ram #(
    parameter int pDepth = 1024,
    parameter int pAddrW = $clog2(pDepth)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [pAddrW-1:0] addr,
    input  logic [31:0]       wrData,
    output logic [31:0]       rdData
);

    logic [31:0] mem [pDepth];

    // Byte-masked write and read-before-write registered read
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][i*8 +: 8] <= wrData[i*8 +: 8];
                end
            end
            rdData <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_stage.sv
// Memory-access stage: byte/half/word loads and stores on the data RAM,
// merged in program order with ALU results through a fixed two-stage pipe.
// Optional misalignment trapping: define DATA_MEM_ALIGN_CHECK_EN.
module data_mem_stage
    import data_mem_stage_pkg::*;
#(
    parameter int pDepth = cRamDepth
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_stage_if.slave bus
);

    localparam int cAddrW = $clog2(pDepth);

    tMemOp        memOp;
    tRegOp        aluRegOp;
    logic [1:0]   lane;
    logic [cAddrW-1:0] ramIdx;
    logic         legalLoad;
    logic         legalStore;
    logic         misNow;
    logic         doLoad;
    logic         doStore;
    logic         ramEn;
    logic [3:0]   ramWe;
    logic [31:0]  ramWrData;
    logic [31:0]  ramRdData;
    tMemStage     s1Reg, s1Next;
    tRegOp        s2Reg, s2Next;
    logic         unusedBits;

    assign memOp    = bus.iAluOut.memOp;
    assign aluRegOp = bus.iAluOut.regOp;
    assign lane     = memOp.addr[1:0];
    assign ramIdx   = memOp.addr[cAddrW+1:2];
    assign unusedBits = ^{bus.iAluOut.brchOp, memOp.addr[cXLEN-1:cAddrW+2]};

    // Decode the request: legality, alignment, byte enables and S1 contents
    always_comb begin
        legalLoad  = memOp.opType inside {eLb, eLh, eLw, eLbu, eLhu};
        legalStore = memOp.opType inside {eLb, eLh, eLw};
`ifdef DATA_MEM_ALIGN_CHECK_EN
        misNow = (memOp.read ^ memOp.write) && misaligned(memOp.opType, lane)
                 && (memOp.read ? legalLoad : legalStore);
`else
        misNow = 1'b0;
`endif
        doLoad  = memOp.read && !memOp.write && legalLoad && !misNow;
        doStore = memOp.write && !memOp.read && legalStore && !misNow;
        ramEn   = doLoad || doStore;

        ramWe     = 4'b0000;
        ramWrData = memOp.data[31:0];
        case (memOp.opType)
            eLb: begin
                ramWe     = 4'b0001 << lane;
                ramWrData = {4{memOp.data[7:0]}};
            end
            eLh: begin
                ramWe     = lane[1] ? 4'b1100 : 4'b0011;
                ramWrData = {2{memOp.data[15:0]}};
            end
            default: ramWe = 4'b1111;
        endcase
        if (!doStore) begin
            ramWe = 4'b0000;
        end

        s1Next.isLoad = doLoad;
        s1Next.opType = memOp.opType;
        s1Next.lane   = lane;
        s1Next.rdAddr = memOp.rdAddr;
        s1Next.regOp  = aluRegOp;
        if (doLoad) begin
            s1Next.dv = memOp.rdAddr != 5'd0;
        end else if (memOp.read || memOp.write) begin
            // Stores pass regOp; illegal or trapped accesses produce nothing
            s1Next.dv = doStore && aluRegOp.dv && (aluRegOp.addr != 5'd0);
        end else begin
            s1Next.dv = aluRegOp.dv && (aluRegOp.addr != 5'd0);
        end
    end

    data_ram #(
        .pDepth (pDepth),
        .pAddrW (cAddrW)
    ) u_ram (
        .clk    (clk),
        .en     (ramEn),
        .we     (ramWe),
        .addr   (ramIdx),
        .wrData (ramWrData),
        .rdData (ramRdData)
    );

    // S1 register: request bookkeeping alongside the RAM read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s1Reg <= '0;
        else     s1Reg <= s1Next;
    end

    // Select load data or the delayed ALU result for the writeback slot
    always_comb begin
        s2Next.dv = s1Reg.dv;
        if (s1Reg.isLoad) begin
            s2Next.addr = s1Reg.rdAddr;
            s2Next.data = loadExtend(s1Reg.opType, s1Reg.lane, ramRdData);
        end else begin
            s2Next.addr = s1Reg.regOp.addr;
            s2Next.data = s1Reg.regOp.data;
        end
    end

    // S2 register: the writeback presented to the register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s2Reg <= '0;
        else     s2Reg <= s2Next;
    end

    assign bus.oRegOp         = s2Reg;
    assign bus.oLoadPend.dv   = s1Reg.dv && s1Reg.isLoad;
    assign bus.oLoadPend.addr = s1Reg.rdAddr;
    assign bus.oLoadPend.data = '0;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic misS1Reg, misS2Reg;

    // Carry the misalignment flag alongside its writeback slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misS1Reg <= 1'b0;
            misS2Reg <= 1'b0;
        end else begin
            misS1Reg <= misNow;
            misS2Reg <= misS1Reg;
        end
    end

    assign bus.oMisalign = misS2Reg;
`endif

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed table-driven bench for data_mem_stage plus hand-written reset
// sequences. Build with DATA_MEM_ALIGN_CHECK_EN to exercise the trap option.
module tb_data_mem_stage;
    import data_mem_stage_pkg::*;

    typedef struct {
        tMemOp      memOp;
        tRegOp      regOp;
        tRegOp      expWb;
        logic       expPend;
        logic       expMis;
    } tVec;

    logic clk;
    logic rst;
    int   nChecks;
    int   nPass;
    tVec  vecs[$];

    data_mem_stage_if bus ();

    data_mem_stage #(.pDepth(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic tVec vMem(input logic rd, input logic wr, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] rdA, input tRegOp alu, input tRegOp expWb,
                                 input logic expPend, input logic expMis);
        tVec v;
        v.memOp.read   = rd;
        v.memOp.write  = wr;
        v.memOp.opType = tMemOpType'(op);
        v.memOp.addr   = addr;
        v.memOp.data   = data;
        v.memOp.rdAddr = rdA;
        v.regOp        = alu;
        v.expWb        = expWb;
        v.expPend      = expPend;
        v.expMis       = expMis;
        return v;
    endfunction

    function automatic tVec vLoad(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [4:0] rdA, input logic expDv,
                                  input logic [31:0] expData);
        return vMem(1'b1, 1'b0, op, addr, 32'h0, rdA, '0, '{expDv, rdA, expData}, expDv, 1'b0);
    endfunction

    function automatic tVec vStore(input logic [2:0] op, input logic [31:0] addr,
                                   input logic [31:0] data);
        return vMem(1'b0, 1'b1, op, addr, data, 5'd0, '0, '0, 1'b0, 1'b0);
    endfunction

    function automatic tVec vAlu(input logic [4:0] rdA, input logic [31:0] data,
                                 input logic expDv);
        return vMem(1'b0, 1'b0, eLb, 32'h0, 32'h0, 5'd0, '{1'b1, rdA, data},
                    '{expDv, rdA, data}, 1'b0, 1'b0);
    endfunction

    task automatic driveIdle();
        bus.iAluOut = '0;
    endtask

    task automatic driveVec(input tVec v);
        bus.iAluOut.memOp  = v.memOp;
        bus.iAluOut.regOp  = v.regOp;
        bus.iAluOut.brchOp = '0;
    endtask

    task automatic chkWb(input string name, input tRegOp exp);
        if (exp.dv) chk(name, 64'({bus.oRegOp.dv, bus.oRegOp.addr, bus.oRegOp.data}),
                        64'({exp.dv, exp.addr, exp.data}));
        else        chk(name, 64'(bus.oRegOp.dv), 64'(1'b0));
    endtask

    task automatic chkPend(input string name, input logic expDv, input logic [4:0] expAddr);
        if (expDv) chk(name, 64'({bus.oLoadPend.dv, bus.oLoadPend.addr}), 64'({1'b1, expAddr}));
        else       chk(name, 64'(bus.oLoadPend.dv), 64'(1'b0));
    endtask

    initial begin
        nChecks = 0;
        nPass   = 0;
        rst     = 1'b1;
        driveIdle();

        vecs.push_back(vStore(eLw, 32'h10, 32'hDEADBEEF));
        vecs.push_back(vLoad(eLw,  32'h10, 5'd5,  1'b1, 32'hDEADBEEF));
        vecs.push_back(vLoad(eLb,  32'h13, 5'd6,  1'b1, 32'hFFFFFFDE));
        vecs.push_back(vLoad(eLbu, 32'h13, 5'd7,  1'b1, 32'h000000DE));
        vecs.push_back(vLoad(eLh,  32'h10, 5'd9,  1'b1, 32'hFFFFBEEF));
        vecs.push_back(vLoad(eLhu, 32'h10, 5'd10, 1'b1, 32'h0000BEEF));
        vecs.push_back(vStore(eLb, 32'h11, 32'h00000055));
        vecs.push_back(vLoad(eLw,  32'h10, 5'd11, 1'b1, 32'hDEAD55EF));
        vecs.push_back(vAlu(5'd3, 32'd7, 1'b1));
        vecs.push_back(vLoad(eLw,  32'h10, 5'd4,  1'b1, 32'hDEAD55EF));
        vecs.push_back(vAlu(5'd6, 32'd9, 1'b1));
        vecs.push_back(vLoad(eLw,  32'h10, 5'd0,  1'b0, 32'h0));
        vecs.push_back(vLoad(eLw,  32'h10, 5'd8,  1'b1, 32'hDEAD55EF));
        vecs.push_back(vAlu(5'd0, 32'd5, 1'b0));
        vecs.push_back(vStore(eLw, 32'h20, 32'h11223344));
        vecs.push_back(vLoad(eLh,  32'h22, 5'd12, 1'b1, 32'h00001122));
        vecs.push_back(vLoad(eLb,  32'h21, 5'd13, 1'b1, 32'h00000033));
        vecs.push_back(vStore(eLh, 32'h26, 32'hABCD8765));
        vecs.push_back(vLoad(eLhu, 32'h26, 5'd14, 1'b1, 32'h00008765));
        vecs.push_back(vLoad(eLh,  32'h26, 5'd15, 1'b1, 32'hFFFF8765));
        vecs.push_back(vMem(1'b1, 1'b0, 3'd3, 32'h10, 32'h0, 5'd16, '{1'b1, 5'd2, 32'd5},
                            '0, 1'b0, 1'b0));
        vecs.push_back(vMem(1'b1, 1'b1, eLw, 32'h10, 32'h0, 5'd17, '{1'b1, 5'd2, 32'd5},
                            '0, 1'b0, 1'b0));
        vecs.push_back(vLoad(eLw,  32'h10, 5'd18, 1'b1, 32'hDEAD55EF));
        vecs.push_back(vMem(1'b0, 1'b1, eLw, 32'h30, 32'h0, 5'd0, '{1'b1, 5'd13, 32'h99},
                            '{1'b1, 5'd13, 32'h99}, 1'b0, 1'b0));
`ifdef DATA_MEM_ALIGN_CHECK_EN
        vecs.push_back(vMem(1'b1, 1'b0, eLw, 32'h12, 32'h0, 5'd19, '0, '0, 1'b0, 1'b1));
`else
        vecs.push_back(vLoad(eLw,  32'h12, 5'd19, 1'b1, 32'hDEAD55EF));
`endif
        vecs.push_back(vAlu(5'd20, 32'h42, 1'b1));

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_regop_dv", 64'(bus.oRegOp), 64'(0));
        chk("reset_loadpend", 64'(bus.oLoadPend), 64'(0));
`ifdef DATA_MEM_ALIGN_CHECK_EN
        chk("reset_misalign", 64'(bus.oMisalign), 64'(0));
`endif
        rst = 1'b0;

        // Back-to-back table: pend checked in N+1, writeback in N+2
        for (int i = 0; i < vecs.size() + 2; i++) begin
            @(negedge clk);
            if (i >= 1) chkPend($sformatf("vec%0d_pend", i - 1), vecs[i-1].expPend,
                                vecs[i-1].memOp.rdAddr);
            if (i >= 2) begin
                chkWb($sformatf("vec%0d_wb", i - 2), vecs[i-2].expWb);
`ifdef DATA_MEM_ALIGN_CHECK_EN
                chk($sformatf("vec%0d_mis", i - 2), 64'(bus.oMisalign), 64'(vecs[i-2].expMis));
`endif
            end
            if (i < vecs.size()) driveVec(vecs[i]);
            else                 driveIdle();
            $display("vec %0d applied", i);
        end

        // Reset while a load sits in S1 discards it
        driveVec(vLoad(eLw, 32'h10, 5'd9, 1'b1, 32'hDEAD55EF));
        @(negedge clk);
        driveIdle();
        chkPend("rstflight_pend", 1'b1, 5'd9);
        rst = 1'b1;
        @(negedge clk);
        chk("rstflight_wb_in_reset", 64'(bus.oRegOp.dv), 64'(0));
        chk("rstflight_pend_cleared", 64'(bus.oLoadPend.dv), 64'(0));
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstflight_wb_after%0d", k), 64'(bus.oRegOp.dv), 64'(0));
        end
        $display("reset-in-flight sequence done");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
